// File: rtl/p2s_rr_scheduler_if.sv
// Requester/serializer bundle for p2s_rr_scheduler: the master side (requesters + serializer)
// drives words and the completed flag, and the slave side (scheduler) drives grants and load.
interface p2s_rr_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          ser_load;
  logic [DATA_WIDTH-1:0]         ser_parin;
  logic                          ser_completed;
  logic                          busy;
  logic                          frame_done;
  logic [IW-1:0]                 frame_id;
  logic                          timeout_err;

  modport master (
    output req_valid, req_data, ser_completed,
    input  req_ready, ser_load, ser_parin, busy, frame_done, frame_id, timeout_err
  );

  modport slave (
    input  req_valid, req_data, ser_completed,
    output req_ready, ser_load, ser_parin, busy, frame_done, frame_id, timeout_err
  );
endinterface

// File: rtl/p2s_rr_scheduler.sv
// Round-robin scheduler sharing one parallel-to-serial serializer between NUM_REQ requesters.
// Optional SHIFT-state watchdog enabled by defining P2S_SCHED_TIMEOUT_EN.
module p2s_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  p2s_rr_scheduler_if.slave bus,
  output logic [1:0]        fsm_state
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         last_grant;
  logic                  found;
  logic [IW-1:0]         winner;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] win_data;
  int                    idx;

  // Handshake: in IDLE only, req_ready is the one-hot of the round-robin winner and is
  // raised only while that requester's req_valid is high; the word transfers on the
  // clock edge where valid & ready, after which the requester may drop or change it.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    grant    = '0;
    win_data = '0;
    idx      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        winner     = IW'(idx);
        grant[idx] = 1'b1;
        win_data   = bus.req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign bus.busy      = (state != IDLE);
  assign fsm_state     = state;

`ifdef P2S_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_cnt;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= IW'(NUM_REQ - 1);
      bus.ser_load   <= 1'b0;
      bus.ser_parin  <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_id   <= '0;
`ifdef P2S_SCHED_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
      wd_cnt          <= '0;
`endif
    end else begin
      bus.ser_load   <= 1'b0;
      bus.frame_done <= 1'b0;
`ifdef P2S_SCHED_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            bus.ser_parin <= win_data;
            bus.frame_id  <= winner;
            last_grant    <= winner;
            bus.ser_load  <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          // SHIFT starts after the load edge so a stale completed is never sampled.
          state <= SHIFT;
`ifdef P2S_SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        SHIFT: begin
          if (bus.ser_completed) begin
            bus.frame_done <= 1'b1;
            state          <= IDLE;
          end
`ifdef P2S_SCHED_TIMEOUT_EN
          else if (wd_cnt == TW'(TIMEOUT_CYC - 1)) begin
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Directed bench for p2s_rr_scheduler with a behavioural MSB-first serializer model.
// Covers the P2S_SCHED_TIMEOUT_EN watchdog when that macro is defined for the build.
module tb_p2s_rr_scheduler;
  logic clk;
  logic reset;
  logic [1:0] fsm_state;
  int cyc;
  int checks;
  int errors;
  int loads;

  p2s_rr_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(4)) bus ();

  p2s_rr_scheduler #(.NUM_REQ(4), .DATA_WIDTH(4), .TIMEOUT_CYC(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // serializer model: MSB first, completed high with the last bit
  logic [3:0] sh;
  logic [3:0] sbits;
  int         scnt;
  logic       sact;
  logic       comp_mask;
  logic       comp_inject;

  always @(posedge clk) begin
    if (reset) begin
      sact <= 1'b0;
      scnt <= 0;
      sh   <= '0;
    end else if (bus.ser_load) begin
      sh   <= bus.ser_parin;
      scnt <= 4;
      sact <= 1'b1;
    end else if (sact) begin
      sh   <= sh << 1;
      scnt <= scnt - 1;
      if (scnt == 1) sact <= 1'b0;
    end
  end

  assign bus.ser_completed = ((sact && scnt == 1) && !comp_mask) || comp_inject;

  // scoreboard
  logic [3:0] exp_q[$];
  logic [1:0] id_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sact) sbits <= {sbits[2:0], sh[3]};
    if (!reset && bus.ser_load) begin
      loads++;
      if (exp_q.size() == 0) check("load_unexpected", 1, 0);
      else check("ser_parin", bus.ser_parin, exp_q.pop_front());
    end
    if (!reset && bus.frame_done) begin
      if (id_q.size() == 0) check("frame_done_unexpected", 1, 0);
      else check("frame_id", bus.frame_id, id_q.pop_front());
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] d);
    bus.req_valid = v;
    bus.req_data  = d;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag, output int at);
    int i;
    for (i = 0; i < 30; i++) begin
      if (bus.frame_done) break;
      next_cycle();
    end
    if (i == 30) check({tag, "_fd_timeout"}, 1, 0);
    at = cyc;
  endtask

  int t0;
  int fd;
  int acc[4];
  int loads0;
  int cnt;
  logic [3:0] w2[4];

  initial begin
    checks = 0; errors = 0; loads = 0;
    sbits = '0;
    reset = 1'b1;
    comp_mask = 1'b0;
    comp_inject = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    w2 = '{4'h5, 4'h3, 4'hC, 4'h9};

    // reset state
    repeat (3) next_cycle();
    check("rst_ser_load", bus.ser_load, 0);
    check("rst_ser_parin", bus.ser_parin, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_frame_id", bus.frame_id, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;
    next_cycle();
    check("idle_no_valid_ready", bus.req_ready, 0);

    // 1: single word 0xA from requester 0
    drive(4'b0001, 16'h000A);
    check("t1_ready", bus.req_ready, 4'b0001);
    exp_q.push_back(4'hA); id_q.push_back(2'd0);
    t0 = cyc;
    next_cycle();
    drive(4'b0000, 16'h000A);
    check("t1_load", bus.ser_load, 1);
    check("t1_parin", bus.ser_parin, 4'hA);
    check("t1_busy", bus.busy, 1);
    check("t1_state_load", fsm_state, 1);
    check("t1_ready_busy", bus.req_ready, 0);
    next_cycle();
    check("t1_load_one_cycle", bus.ser_load, 0);
    wait_frame_done("t1", fd);
    check("t1_latency", fd - t0, 6);
    check("t1_serial", sbits, 4'hA);
    check("t1_frame_id", bus.frame_id, 0);
    check("t1_busy_at_done", bus.busy, 0);
    next_cycle();
    check("t1_done_pulse", bus.frame_done, 0);

    // 2: all valid -> order 0,1,2,3
    do_reset();
    loads0 = loads;
    drive(4'b1111, 16'h9C35);
    for (int k = 0; k < 4; k++) begin
      check("t2_ready", bus.req_ready, 32'(4'b0001 << k));
      exp_q.push_back(w2[k]); id_q.push_back(2'(k));
      acc[k] = cyc;
      next_cycle();
      wait_frame_done("t2", fd);
    end
    drive(4'b0000, 16'h9C35);
    for (int k = 1; k < 4; k++) check("t2_spacing", acc[k] - acc[k-1], 6);
    next_cycle();
    check("t2_loads", loads - loads0, 4);

    // 3: last grant 2, then 0101 -> 0 then 2
    drive(4'b0100, 16'h0700);
    check("t3_ready_2", bus.req_ready, 4'b0100);
    exp_q.push_back(4'h7); id_q.push_back(2'd2);
    next_cycle();
    drive(4'b0000, 16'h0700);
    wait_frame_done("t3a", fd);
    next_cycle();
    drive(4'b0101, 16'h0B0E);
    check("t3_wrap_ready_0", bus.req_ready, 4'b0001);
    exp_q.push_back(4'hE); id_q.push_back(2'd0);
    next_cycle();
    drive(4'b0100, 16'h0B0E);
    check("t3_ready_busy", bus.req_ready, 0);
    wait_frame_done("t3b", fd);
    check("t3_next_ready_2", bus.req_ready, 4'b0100);
    exp_q.push_back(4'hB); id_q.push_back(2'd2);
    next_cycle();
    drive(4'b0000, 16'h0B0E);
    wait_frame_done("t3c", fd);

    // 4: request while busy; completed injected during LOAD is ignored
    next_cycle();
    drive(4'b0001, 16'h00D4);
    check("t4_ready_0", bus.req_ready, 4'b0001);
    exp_q.push_back(4'h4); id_q.push_back(2'd0);
    t0 = cyc;
    next_cycle();
    comp_inject = 1'b1;
    drive(4'b0010, 16'h00D4);
    check("t4_ready_in_load", bus.req_ready, 0);
    next_cycle();
    comp_inject = 1'b0;
    cnt = 0;
    while (!bus.frame_done && cnt < 30) begin
      check("t4_ready_busy", bus.req_ready, 0);
      next_cycle();
      cnt++;
    end
    check("t4_latency", cyc - t0, 6);
    check("t4_ready_1", bus.req_ready, 4'b0010);
    exp_q.push_back(4'hD); id_q.push_back(2'd1);
    next_cycle();
    drive(4'b0000, 16'h00D4);
    wait_frame_done("t4", fd);
    next_cycle();
    comp_inject = 1'b1;
    next_cycle();
    comp_inject = 1'b0;
    #1;
    check("t4_idle_completed_done", bus.frame_done, 0);
    check("t4_idle_completed_busy", bus.busy, 0);

    // 5: reset two cycles after ser_load
    drive(4'b0100, 16'h0300);
    check("t5_ready_2", bus.req_ready, 4'b0100);
    exp_q.push_back(4'h3);
    next_cycle();
    drive(4'b0000, 16'h0300);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("t5_busy", bus.busy, 0);
    check("t5_ser_load", bus.ser_load, 0);
    check("t5_frame_done", bus.frame_done, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.frame_done) cnt++;
      next_cycle();
    end
    check("t5_no_done_after_abort", cnt, 0);
    drive(4'b1111, 16'h1234);
    check("t5_restart_ready_0", bus.req_ready, 4'b0001);
    exp_q.push_back(4'h4); id_q.push_back(2'd0);
    next_cycle();
    drive(4'b0000, 16'h1234);
    wait_frame_done("t5", fd);

    // 6: serializer never completes
    next_cycle();
    comp_mask = 1'b1;
    drive(4'b0001, 16'h0002);
    check("t6_ready", bus.req_ready, 4'b0001);
    exp_q.push_back(4'h2);
    t0 = cyc;
    next_cycle();
    drive(4'b0000, 16'h0002);
`ifdef P2S_SCHED_TIMEOUT_EN
    cnt = 0;
    while (!bus.timeout_err && cnt < 30) begin
      check("t6_no_done", bus.frame_done, 0);
      next_cycle();
      cnt++;
    end
    check("t6_timeout_at", cyc - t0, 10);
    check("t6_busy", bus.busy, 0);
    next_cycle();
    check("t6_pulse", bus.timeout_err, 0);
    comp_mask = 1'b0;
    drive(4'b0011, 16'h0081);
    check("t6_ptr_advanced", bus.req_ready, 4'b0010);
    exp_q.push_back(4'h8); id_q.push_back(2'd1);
    next_cycle();
    drive(4'b0000, 16'h0081);
    wait_frame_done("t6", fd);
`else
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.timeout_err) cnt++;
      next_cycle();
    end
    check("t6_no_timeout", cnt, 0);
    check("t6_still_busy", bus.busy, 1);
    check("t6_still_shift", fsm_state, 2);
    do_reset();
    comp_mask = 1'b0;
    check("t6_reset_idle", bus.busy, 0);
`endif

    next_cycle();
    check("exp_q_drained", exp_q.size(), 0);
    check("id_q_drained", id_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1);
  end
endmodule
